// File: rtl/bram_port_arbiter_pkg.sv
// Shared encodings for the BRAM port arbiter: FSM states, requester ids and read tags.
package bram_port_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StOwnA = 2'd1,
    StOwnB = 2'd2
  } arb_state_e;

  typedef enum logic {
    OwnA = 1'b0,
    OwnB = 1'b1
  } owner_e;

  // One in-flight read: which requester gets the data when it returns.
  typedef struct packed {
    logic   valid;
    owner_e owner;
  } rd_tag_t;

endpackage

// File: rtl/bram_port_arbiter_rd_tag_pipe.sv
// Delay line of read tags matching the BRAM read latency; the last stage drives the
// per-requester read-valid pulses.
module bram_port_arbiter_rd_tag_pipe
  import bram_port_arbiter_pkg::*;
#(
  parameter int unsigned RD_LAT = 1
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  owner_e push_owner,
  output logic   a_rvalid,
  output logic   b_rvalid
);

  // Stage 0 lines up with the BRAM pin registers, stage RD_LAT with valid douta.
  rd_tag_t [RD_LAT:0] pipe_q, pipe_d;

  // Shift the tags one stage per cycle, inserting the current beat at the head.
  always_comb begin
    pipe_d    = pipe_q;
    pipe_d[0] = '{valid: push, owner: push_owner};
    for (int unsigned i = 1; i <= RD_LAT; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  // Tag register; reset drops every read still in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign a_rvalid = pipe_q[RD_LAT].valid && (pipe_q[RD_LAT].owner == OwnA);
  assign b_rvalid = pipe_q[RD_LAT].valid && (pipe_q[RD_LAT].owner == OwnB);

endmodule

// File: rtl/bram_port_arbiter.sv
// Two-requester arbiter for a single BRAM port: round-robin ownership with an optional
// bounded lock, registered BRAM pins, and read data steered back by a tag pipeline.
module bram_port_arbiter
  import bram_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned RD_LAT   = 1,
  parameter int unsigned MAX_LOCK = 16
) (
  input  logic              clk,
  input  logic              rst,
  // Requester A
  input  logic              a_req,
  input  logic              a_lock,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  // Requester B
  input  logic              b_req,
  input  logic              b_lock,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  // BRAM port
  output logic              bram_ena,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_din,
  input  logic [DATA_W-1:0] bram_dout
);

  localparam int unsigned LockW = (MAX_LOCK > 1) ? $clog2(MAX_LOCK) : 1;
  localparam logic [LockW-1:0] LockLast = LockW'(MAX_LOCK - 1);

  arb_state_e        state_q, state_d;
  owner_e            prio_q, prio_d;
  logic [LockW-1:0]  lock_cnt_q, lock_cnt_d;

  logic              a_acc, b_acc, acc, lock_hit;
  owner_e            sel;
  logic              cmd_we;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;

  logic              ena_q, we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] din_q;

  // Grants come straight from the state register, so they are glitch-free.
  assign a_gnt    = (state_q == StOwnA);
  assign b_gnt    = (state_q == StOwnB);
  assign a_acc    = a_req & a_gnt;
  assign b_acc    = b_req & b_gnt;
  assign acc      = a_acc | b_acc;
  assign sel      = b_acc ? OwnB : OwnA;
  assign lock_hit = acc && (lock_cnt_q == LockLast);

  // Command mux: only the current owner can have an accepted beat.
  always_comb begin
    cmd_we    = a_we;
    cmd_addr  = a_addr;
    cmd_wdata = a_wdata;
    if (sel == OwnB) begin
      cmd_we    = b_we;
      cmd_addr  = b_addr;
      cmd_wdata = b_wdata;
    end
  end

  // Ownership next-state, round-robin priority and lock counter.
  always_comb begin
    state_d    = state_q;
    prio_d     = prio_q;
    lock_cnt_d = lock_cnt_q;

    unique case (state_q)
      StIdle: begin
        if (a_req && (!b_req || prio_q == OwnA)) begin
          state_d = StOwnA;
        end else if (b_req) begin
          state_d = StOwnB;
        end
      end
      StOwnA: begin
        if (b_req && (!a_req || !a_lock || lock_hit)) begin
          state_d = StOwnB;
        end else if (!a_req && !b_req) begin
          state_d = StIdle;
        end
      end
      StOwnB: begin
        if (a_req && (!b_req || !b_lock || lock_hit)) begin
          state_d = StOwnA;
        end else if (!a_req && !b_req) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (state_d != state_q && state_d != StIdle) begin
      // New owner: the other side gets priority next time and the lock window restarts.
      prio_d     = (state_d == StOwnA) ? OwnB : OwnA;
      lock_cnt_d = '0;
    end else if (state_d == state_q && acc && lock_cnt_q != LockLast) begin
      // Saturate so a waiter arriving late still sees the limit on the next beat.
      lock_cnt_d = lock_cnt_q + 1'b1;
    end
  end

  // Arbiter state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      prio_q     <= OwnA;
      lock_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      prio_q     <= prio_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  // BRAM pin registers; address and data hold their last value between beats.
  always_ff @(posedge clk) begin
    if (rst) begin
      ena_q  <= 1'b0;
      we_q   <= 1'b0;
      addr_q <= '0;
      din_q  <= '0;
    end else begin
      ena_q <= acc;
      we_q  <= acc & cmd_we;
      if (acc) begin
        addr_q <= cmd_addr;
        din_q  <= cmd_wdata;
      end
    end
  end

  assign bram_ena  = ena_q;
  assign bram_we   = we_q;
  assign bram_addr = addr_q;
  assign bram_din  = din_q;

  bram_port_arbiter_rd_tag_pipe #(
    .RD_LAT (RD_LAT)
  ) u_rd_tag_pipe (
    .clk        (clk),
    .rst        (rst),
    .push       (acc & ~cmd_we),
    .push_owner (sel),
    .a_rvalid   (a_rvalid),
    .b_rvalid   (b_rvalid)
  );

  // Both requesters see the raw BRAM output; only the valids are steered.
  assign a_rdata = bram_dout;
  assign b_rdata = bram_dout;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Self-checking bench for bram_port_arbiter with a 1-cycle-latency BRAM model and a
// response scoreboard.
module tb_bram_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  typedef struct {
    bit          owner;  // 0 = A, 1 = B
    logic [31:0] data;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          a_req = 0, a_lock = 0, a_we = 0;
  logic [AW-1:0] a_addr = '0;
  logic [DW-1:0] a_wdata = '0;
  logic          b_req = 0, b_lock = 0, b_we = 0;
  logic [AW-1:0] b_addr = '0;
  logic [DW-1:0] b_wdata = '0;
  logic          a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [DW-1:0] a_rdata, b_rdata;
  logic          bram_ena, bram_we;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_din;
  logic [DW-1:0] bram_dout = '0;

  logic [DW-1:0] mem    [64];
  logic [DW-1:0] shadow [64];
  exp_t          sb[$];
  int            n_checks = 0;
  int            n_pass   = 0;
  int            a_cnt    = 0;
  int            b_cnt    = 0;

  always #5 clk = ~clk;

  bram_port_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .a_req     (a_req),
    .a_lock    (a_lock),
    .a_we      (a_we),
    .a_addr    (a_addr),
    .a_wdata   (a_wdata),
    .a_gnt     (a_gnt),
    .a_rvalid  (a_rvalid),
    .a_rdata   (a_rdata),
    .b_req     (b_req),
    .b_lock    (b_lock),
    .b_we      (b_we),
    .b_addr    (b_addr),
    .b_wdata   (b_wdata),
    .b_gnt     (b_gnt),
    .b_rvalid  (b_rvalid),
    .b_rdata   (b_rdata),
    .bram_ena  (bram_ena),
    .bram_we   (bram_we),
    .bram_addr (bram_addr),
    .bram_din  (bram_din),
    .bram_dout (bram_dout)
  );

  // BRAM model, read latency 1.
  always @(posedge clk) begin
    if (bram_ena) begin
      if (bram_we) mem[bram_addr[7:2]] <= bram_din;
      else bram_dout <= mem[bram_addr[7:2]];
    end
  end

  // Response monitor: every rvalid pulse is matched against the scoreboard head.
  always @(negedge clk) begin
    exp_t        e;
    bit          got_owner;
    logic [31:0] got_data;
    if (a_rvalid || b_rvalid) begin
      n_checks++;
      if (a_rvalid && b_rvalid) begin
        $display("FAIL rvalid_excl: a_rvalid=1 b_rvalid=1, required at most one");
      end else if (sb.size() == 0) begin
        $display("FAIL rvalid_unexpected: a_rvalid=%0b b_rvalid=%0b, required none",
                 a_rvalid, b_rvalid);
      end else begin
        e         = sb.pop_front();
        got_owner = b_rvalid;
        got_data  = b_rvalid ? b_rdata : a_rdata;
        if (got_owner !== e.owner || got_data !== e.data)
          $display("FAIL rsp: owner=%0d data=%h, required owner=%0d data=%h",
                   got_owner, got_data, e.owner, e.data);
        else n_pass++;
      end
      if (a_rvalid) a_cnt++;
      if (b_rvalid) b_cnt++;
    end
  end

  // Note what the DUT accepts this cycle, then advance to the next negedge.
  task automatic tick();
    exp_t e;
    bit          own;
    logic        we;
    logic [31:0] addr, wd;
    if (!rst && ((a_req && a_gnt) || (b_req && b_gnt))) begin
      own  = !(a_req && a_gnt);
      we   = own ? b_we : a_we;
      addr = own ? b_addr : a_addr;
      wd   = own ? b_wdata : a_wdata;
      if (we) begin
        shadow[addr[7:2]] = wd;
      end else begin
        e.owner = own;
        e.data  = shadow[addr[7:2]];
        sb.push_back(e);
      end
    end
    @(negedge clk);
  endtask

  task automatic idle_reqs();
    a_req = 0; a_lock = 0; a_we = 0;
    b_req = 0; b_lock = 0; b_we = 0;
  endtask

  task automatic do_reset();
    idle_reqs();
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    sb.delete();
    a_cnt = 0;
    b_cnt = 0;
  endtask

  task automatic drain(input string name);
    idle_reqs();
    repeat (4) tick();
    n_checks++;
    if (sb.size() != 0) $display("FAIL %s_drain: %0d responses outstanding, required 0",
                                 name, sb.size());
    else n_pass++;
  endtask

  task automatic test_reset();
    idle_reqs();
    rst = 1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({a_gnt, b_gnt, bram_ena, bram_we, a_rvalid, b_rvalid} !== 6'b0)
      $display("FAIL reset_ctl: gnt/ena/we/rvalid=%b, required 000000",
               {a_gnt, b_gnt, bram_ena, bram_we, a_rvalid, b_rvalid});
    else n_pass++;
    n_checks++;
    if (bram_addr !== '0 || bram_din !== '0)
      $display("FAIL reset_pins: addr=%h din=%h, required 0", bram_addr, bram_din);
    else n_pass++;
    rst = 0;
    @(negedge clk);
    n_checks++;
    if ({a_gnt, b_gnt} !== 2'b00) $display("FAIL reset_idle: gnt=%b, required 00", {a_gnt, b_gnt});
    else n_pass++;
  endtask

  task automatic test_only_a();
    int waited;
    do_reset();
    for (int k = 0; k < 10; k++) begin
      a_req = 1; a_lock = 0; a_we = 1; a_addr = 32'(4 * k); a_wdata = 32'(k + 1);
      waited = 0;
      while (!a_gnt && waited < 8) begin
        tick();
        waited++;
      end
      n_checks++;
      if (a_gnt !== 1'b1) $display("FAIL only_a_wgnt: a_gnt=%b at write %0d, required 1", a_gnt, k);
      else n_pass++;
      tick();
    end
    for (int k = 0; k < 10; k++) begin
      a_lock = 1; a_we = 0; a_addr = 32'(4 * k);
      n_checks++;
      if (a_gnt !== 1'b1) $display("FAIL only_a_rgnt: a_gnt=%b at read %0d, required 1", a_gnt, k);
      else n_pass++;
      tick();
    end
    drain("only_a");
    n_checks++;
    if (a_cnt != 10 || b_cnt != 0)
      $display("FAIL only_a_count: a_rvalid=%0d b_rvalid=%0d, required 10 and 0", a_cnt, b_cnt);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic exp_a, exp_b;
    do_reset();
    a_req = 1; b_req = 1; a_lock = 0; b_lock = 0; a_we = 0; b_we = 0;
    for (int c = 0; c < 9; c++) begin
      a_addr = 32'(4 * (c % 10));
      b_addr = 32'(4 * ((c + 3) % 10));
      exp_a  = (c % 2) == 1;
      exp_b  = (c > 0) && ((c % 2) == 0);
      n_checks++;
      if ({a_gnt, b_gnt} !== {exp_a, exp_b})
        $display("FAIL b2b_gnt: cycle %0d gnt=%b, required %b", c, {a_gnt, b_gnt}, {exp_a, exp_b});
      else n_pass++;
      if (c >= 2) begin
        n_checks++;
        if (bram_ena !== 1'b1) $display("FAIL b2b_ena: cycle %0d ena=%b, required 1", c, bram_ena);
        else n_pass++;
      end
      tick();
    end
    drain("b2b");
  endtask

  task automatic test_lock_limit();
    int a_run = 0;
    int b_run = 0;
    do_reset();
    a_req = 1; a_lock = 1; a_we = 0; a_addr = 32'd16;
    b_req = 1; b_lock = 1; b_we = 0; b_addr = 32'd20;
    for (int c = 0; c < 40; c++) begin
      if (b_gnt) break;
      if (a_gnt) a_run++;
      tick();
    end
    n_checks++;
    if (a_run != 16 || b_gnt !== 1'b1)
      $display("FAIL lock_a_run: A beats=%0d b_gnt=%b, required 16 and 1", a_run, b_gnt);
    else n_pass++;
    for (int c = 0; c < 40; c++) begin
      if (a_gnt) break;
      if (b_gnt) b_run++;
      tick();
    end
    n_checks++;
    if (b_run != 16 || a_gnt !== 1'b1)
      $display("FAIL lock_b_run: B beats=%0d a_gnt=%b, required 16 and 1", b_run, a_gnt);
    else n_pass++;
    drain("lock");
  endtask

  task automatic test_handover_read();
    int waited = 0;
    do_reset();
    a_req = 1; a_we = 0; a_addr = 32'd8;
    while (!a_gnt && waited < 8) begin
      tick();
      waited++;
    end
    b_req = 1; b_we = 0; b_addr = 32'd12;
    tick();
    a_req = 0;
    n_checks++;
    if ({a_gnt, b_gnt} !== 2'b01) $display("FAIL ho_gnt: gnt=%b, required 01", {a_gnt, b_gnt});
    else n_pass++;
    tick();
    b_req = 0;
    n_checks++;
    if (a_rvalid !== 1'b1 || a_rdata !== 32'd3)
      $display("FAIL ho_a_rsp: a_rvalid=%b a_rdata=%h, required 1 and 3", a_rvalid, a_rdata);
    else n_pass++;
    tick();
    n_checks++;
    if (b_rvalid !== 1'b1 || b_rdata !== 32'd4)
      $display("FAIL ho_b_rsp: b_rvalid=%b b_rdata=%h, required 1 and 4", b_rvalid, b_rdata);
    else n_pass++;
    drain("ho");
  endtask

  task automatic test_reset_in_flight();
    int waited = 0;
    do_reset();
    a_req = 1; a_we = 0; a_addr = 32'd8;
    while (!a_gnt && waited < 8) begin
      tick();
      waited++;
    end
    tick();
    a_req = 0;
    rst = 1;
    @(negedge clk);
    rst = 0;
    sb.delete();
    n_checks++;
    if ({a_gnt, b_gnt, bram_ena, bram_we, a_rvalid, b_rvalid} !== 6'b0 ||
        bram_addr !== '0 || bram_din !== '0)
      $display("FAIL rif_outs: ctl=%b addr=%h din=%h, required all 0",
               {a_gnt, b_gnt, bram_ena, bram_we, a_rvalid, b_rvalid}, bram_addr, bram_din);
    else n_pass++;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_checks++;
      if (a_rvalid !== 1'b0 || b_rvalid !== 1'b0)
        $display("FAIL rif_rvalid: a=%b b=%b, required 0 0", a_rvalid, b_rvalid);
      else n_pass++;
    end
    // Priority was B before the reset; A must win again now.
    a_req = 1; b_req = 1; a_addr = 32'd0; b_addr = 32'd4;
    tick();
    n_checks++;
    if ({a_gnt, b_gnt} !== 2'b10) $display("FAIL rif_prio: gnt=%b, required 10", {a_gnt, b_gnt});
    else n_pass++;
    drain("rif");
  endtask

  task automatic test_write_then_read();
    int waited = 0;
    do_reset();
    a_req = 1; a_we = 1; a_addr = 32'd4; a_wdata = 32'h55;
    while (!a_gnt && waited < 8) begin
      tick();
      waited++;
    end
    b_req = 1; b_we = 0; b_addr = 32'd4;
    tick();
    a_req = 0;
    tick();
    b_req = 0;
    tick();
    n_checks++;
    if (b_rvalid !== 1'b1 || b_rdata !== 32'h55)
      $display("FAIL wr_rd: b_rvalid=%b b_rdata=%h, required 1 and 55", b_rvalid, b_rdata);
    else n_pass++;
    drain("wr_rd");
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[i]    = '0;
      shadow[i] = '0;
    end
    test_reset();
    test_only_a();
    test_back_to_back();
    test_lock_limit();
    test_handover_read();
    test_reset_in_flight();
    test_write_then_read();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
